// File: rtl/asrv32_dmem_arbiter.sv
// Two-master arbiter for the single-port data RAM: the core (port 0) normally wins,
// the loader (port 1) is forced through after STARVE_LIMIT consecutive waiting cycles.
module asrv32_dmem_arbiter #(
    parameter logic [31:0] RAM_BASE     = 32'h0000_0000,
    parameter int unsigned RAM_DEPTH    = 8192,
    parameter int unsigned MEM_LAT      = 1,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_stb,
    input  logic        p0_wr_en,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_wr_mask,
    output logic        p0_ack,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_stb,
    input  logic        p1_wr_en,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_wr_mask,
    output logic        p1_ack,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    output logic [3:0]  mem_wr_mask,
    input  logic [31:0] mem_data_out
);
    localparam int          LAT     = int'(MEM_LAT);
    localparam logic [31:0] DEPTH_W = 32'(RAM_DEPTH);
    localparam logic [7:0]  LIMIT_W = 8'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        CORE_PRI   = 1'b0,
        LOADER_PRI = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic valid;
        logic port;
        logic err;
    } resp_tag_t;

    // Unsigned wrap-around makes addresses below RAM_BASE land far out of range.
    function automatic logic addr_in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - RAM_BASE;
        return (off < DEPTH_W);
    endfunction

    arb_state_t  state_r;
    logic [7:0]  starve_cnt_r;
    resp_tag_t   tag_pipe_r [LAT];

    logic        gnt0_s;
    logic        gnt1_s;
    logic        gnt_any_s;
    logic        sel_wr_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;
    logic [3:0]  sel_mask_s;
    logic [31:0] sel_off_s;
    logic        sel_in_range_s;
    logic [7:0]  starve_nxt_s;
    resp_tag_t   new_tag_s;
    resp_tag_t   out_tag_s;

    // Grant selection: at most one port per cycle, nothing while in reset.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (rst) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case (state_r)
                CORE_PRI: begin
                    gnt0_s = p0_stb;
                    gnt1_s = p1_stb & ~p0_stb;
                end
                LOADER_PRI: begin
                    gnt1_s = p1_stb;
                    gnt0_s = p0_stb & ~p1_stb;
                end
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
    end

    assign gnt_any_s = gnt0_s | gnt1_s;
    assign p0_ack    = gnt0_s;
    assign p1_ack    = gnt1_s;

    // Request mux towards the RAM, driven by the granted port.
    always_comb begin
        sel_wr_s    = 1'b0;
        sel_addr_s  = 32'h0;
        sel_wdata_s = 32'h0;
        sel_mask_s  = 4'h0;
        if (gnt1_s) begin
            sel_wr_s    = p1_wr_en;
            sel_addr_s  = p1_addr;
            sel_wdata_s = p1_wdata;
            sel_mask_s  = p1_wr_mask;
        end else begin
            sel_wr_s    = p0_wr_en;
            sel_addr_s  = p0_addr;
            sel_wdata_s = p0_wdata;
            sel_mask_s  = p0_wr_mask;
        end
    end

    assign sel_off_s      = sel_addr_s - RAM_BASE;
    assign sel_in_range_s = addr_in_range(sel_addr_s);

    // RAM strobes: out-of-range accesses are acked but never reach the RAM.
    always_comb begin
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = 32'h0;
        mem_data_in = 32'h0;
        mem_wr_mask = 4'h0;
        if (gnt_any_s && sel_in_range_s) begin
            mem_rd_en = ~sel_wr_s;
            mem_wr_en = sel_wr_s;
            mem_addr  = sel_off_s & 32'hFFFF_FFFC;
            if (sel_wr_s) begin
                mem_data_in = sel_wdata_s;
                mem_wr_mask = sel_mask_s;
            end else begin
                mem_data_in = 32'h0;
                mem_wr_mask = 4'h0;
            end
        end else begin
            mem_rd_en = 1'b0;
            mem_wr_en = 1'b0;
        end
    end

    // Saturating count of cycles the loader has waited without being served.
    always_comb begin
        starve_nxt_s = 8'd0;
        if (p1_stb && !gnt1_s) begin
            if (starve_cnt_r == 8'hFF) begin
                starve_nxt_s = starve_cnt_r;
            end else begin
                starve_nxt_s = starve_cnt_r + 8'd1;
            end
        end else begin
            starve_nxt_s = 8'd0;
        end
    end

    // Arbitration FSM and starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= CORE_PRI;
            starve_cnt_r <= 8'd0;
        end else begin
            starve_cnt_r <= starve_nxt_s;
            case (state_r)
                CORE_PRI: begin
                    if (starve_nxt_s >= LIMIT_W) begin
                        state_r <= LOADER_PRI;
                    end else begin
                        state_r <= CORE_PRI;
                    end
                end
                LOADER_PRI: begin
                    if (gnt1_s || !p1_stb) begin
                        state_r <= CORE_PRI;
                    end else begin
                        state_r <= LOADER_PRI;
                    end
                end
                default: state_r <= CORE_PRI;
            endcase
        end
    end

    // Reads and any out-of-range access produce a response; in-range writes do not.
    always_comb begin
        new_tag_s.valid = gnt_any_s & (~sel_in_range_s | ~sel_wr_s);
        new_tag_s.port  = gnt1_s;
        new_tag_s.err   = ~sel_in_range_s;
    end

    // Response tag pipeline aligned with the RAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                tag_pipe_r[i] <= '0;
            end
        end else begin
            tag_pipe_r[0] <= new_tag_s;
            for (int i = 1; i < LAT; i++) begin
                tag_pipe_r[i] <= tag_pipe_r[i-1];
            end
        end
    end

    assign out_tag_s = tag_pipe_r[LAT-1];

    // Route the retiring response to its issuing port; errored responses carry zero data.
    always_comb begin
        p0_rvalid = out_tag_s.valid & ~out_tag_s.port;
        p1_rvalid = out_tag_s.valid & out_tag_s.port;
        p0_err    = p0_rvalid & out_tag_s.err;
        p1_err    = p1_rvalid & out_tag_s.err;
        p0_rdata  = 32'h0;
        p1_rdata  = 32'h0;
        if (out_tag_s.valid && !out_tag_s.err) begin
            if (out_tag_s.port) begin
                p1_rdata = mem_data_out;
            end else begin
                p0_rdata = mem_data_out;
            end
        end else begin
            p0_rdata = 32'h0;
            p1_rdata = 32'h0;
        end
    end
endmodule

// File: tb/tb_asrv32_dmem_arbiter.sv
// Randomized scoreboard bench for asrv32_dmem_arbiter with a behavioural RAM
// and a wait-count arbitration reference.
module tb_asrv32_dmem_arbiter;
    localparam logic [31:0] RAM_BASE     = 32'h8000_0000;
    localparam int          RAM_DEPTH    = 8192;
    localparam int          MEM_LAT      = 2;
    localparam int          STARVE_LIMIT = 8;
    localparam int          WORDS        = RAM_DEPTH / 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_stb = 1'b0, p0_wr_en = 1'b0;
    logic [31:0] p0_addr = 32'h0, p0_wdata = 32'h0;
    logic [3:0]  p0_wr_mask = 4'h0;
    logic        p1_stb = 1'b0, p1_wr_en = 1'b0;
    logic [31:0] p1_addr = 32'h0, p1_wdata = 32'h0;
    logic [3:0]  p1_wr_mask = 4'h0;
    logic        p0_ack, p0_rvalid, p0_err, p1_ack, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_rd_en, mem_wr_en;
    logic [31:0] mem_addr, mem_data_in, mem_data_out;
    logic [3:0]  mem_wr_mask;

    always #5 clk = ~clk;

    asrv32_dmem_arbiter #(
        .RAM_BASE(RAM_BASE), .RAM_DEPTH(RAM_DEPTH),
        .MEM_LAT(MEM_LAT), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .p0_stb(p0_stb), .p0_wr_en(p0_wr_en), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_wr_mask(p0_wr_mask), .p0_ack(p0_ack), .p0_rvalid(p0_rvalid),
        .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_stb(p1_stb), .p1_wr_en(p1_wr_en), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_wr_mask(p1_wr_mask), .p1_ack(p1_ack), .p1_rvalid(p1_rvalid),
        .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_wr_mask(mem_wr_mask), .mem_data_out(mem_data_out)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 32'h1000 / 4) return 32'h1234_5678;
        else if (i == 32'h1004 / 4) return 32'h1122_3344;
        else return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Behavioural single-port RAM; non-read cycles return garbage to expose bad routing.
    logic [31:0] ram [WORDS];
    logic [31:0] rd_pipe [MEM_LAT];
    logic        ram_loaded = 1'b0;
    assign mem_data_out = rd_pipe[MEM_LAT-1];
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < WORDS; i++) ram[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else if (mem_wr_en) begin
            ram[mem_addr[12:2]] <= merge(ram[mem_addr[12:2]], mem_data_in, mem_wr_mask);
        end
        rd_pipe[0] <= mem_rd_en ? ram[mem_addr[12:2]] : 32'hDEAD_BEEF;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] ref_mem [WORDS];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          wait_cnt = 0;
    logic        rst_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected effect of one granted request on the RAM port and the response stream.
    task automatic model_grant(input int port, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] mask);
        logic [31:0] off;
        logic        inr;
        int          idx;
        exp_t        e;
        off = addr - RAM_BASE;
        inr = (off < 32'(RAM_DEPTH));
        idx = int'(off[12:2]);
        chk("mem_rd_en", 32'(mem_rd_en), 32'(inr && !wr));
        chk("mem_wr_en", 32'(mem_wr_en), 32'(inr && wr));
        if (inr) chk("mem_addr", mem_addr, {off[31:2], 2'b00});
        if (inr && wr) begin
            chk("mem_data_in", mem_data_in, wdata);
            chk("mem_wr_mask", 32'(mem_wr_mask), 32'(mask));
            ref_mem[idx] = merge(ref_mem[idx], wdata, mask);
        end else begin
            chk("mem_wr_mask_idle", 32'(mem_wr_mask), 32'h0);
            e.due  = cyc + MEM_LAT;
            e.data = inr ? ref_mem[idx] : 32'h0;
            e.err  = !inr;
            if (port == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic check_resp(input int port, input logic rv, input logic [31:0] rd,
                              input logic er);
        exp_t e;
        logic due;
        due = 1'b0;
        if (port == 0) begin
            if (q0.size() > 0 && q0[0].due <= cyc) begin due = 1'b1; e = q0.pop_front(); end
        end else begin
            if (q1.size() > 0 && q1[0].due <= cyc) begin due = 1'b1; e = q1.pop_front(); end
        end
        chk($sformatf("p%0d_rvalid", port), 32'(rv), 32'(due));
        if (due) begin
            chk($sformatf("p%0d_rdata", port), rd, e.data);
            chk($sformatf("p%0d_err", port), 32'(er), 32'(e.err));
        end
    endtask

    // Monitor: predicts the winner from the loader wait count and scores every cycle.
    initial begin
        logic e0, e1;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_p0_ack", 32'(p0_ack), 32'h0);
                chk("rst_p1_ack", 32'(p1_ack), 32'h0);
                chk("rst_mem_rd_en", 32'(mem_rd_en), 32'h0);
                chk("rst_mem_wr_en", 32'(mem_wr_en), 32'h0);
                chk("rst_mem_wr_mask", 32'(mem_wr_mask), 32'h0);
                if (rst_seen) begin
                    chk("rst_p0_rvalid", 32'(p0_rvalid), 32'h0);
                    chk("rst_p1_rvalid", 32'(p1_rvalid), 32'h0);
                    chk("rst_p0_err", 32'(p0_err), 32'h0);
                    chk("rst_p1_err", 32'(p1_err), 32'h0);
                    chk("rst_p0_rdata", p0_rdata, 32'h0);
                    chk("rst_p1_rdata", p1_rdata, 32'h0);
                end
                q0.delete();
                q1.delete();
                wait_cnt = 0;
                rst_seen = 1'b1;
            end else begin
                rst_seen = 1'b0;
                check_resp(0, p0_rvalid, p0_rdata, p0_err);
                check_resp(1, p1_rvalid, p1_rdata, p1_err);
                e1 = p1_stb && (!p0_stb || wait_cnt >= STARVE_LIMIT);
                e0 = p0_stb && !e1;
                chk("p0_ack", 32'(p0_ack), 32'(e0));
                chk("p1_ack", 32'(p1_ack), 32'(e1));
                if (e0) model_grant(0, p0_wr_en, p0_addr, p0_wdata, p0_wr_mask);
                else if (e1) model_grant(1, p1_wr_en, p1_addr, p1_wdata, p1_wr_mask);
                else begin
                    chk("idle_mem_rd_en", 32'(mem_rd_en), 32'h0);
                    chk("idle_mem_wr_en", 32'(mem_wr_en), 32'h0);
                    chk("idle_mem_wr_mask", 32'(mem_wr_mask), 32'h0);
                end
                wait_cnt = (p1_stb && !e1) ? ((wait_cnt < 255) ? wait_cnt + 1 : 255) : 0;
            end
        end
    end

    // Issue one request and hold it until acked; called just after a rising edge.
    task automatic req(input int port, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask, input int gap);
        logic got;
        int   n;
        if (port == 0) begin
            p0_wr_en = wr; p0_addr = addr; p0_wdata = wdata; p0_wr_mask = mask; p0_stb = 1'b1;
        end else begin
            p1_wr_en = wr; p1_addr = addr; p1_wdata = wdata; p1_wr_mask = mask; p1_stb = 1'b1;
        end
        got = 1'b0;
        n = 0;
        while (!got && n < 64) begin
            @(negedge clk);
            got = (port == 0) ? p0_ack : p1_ack;
            n++;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout p%0d: actual=no ack expected=ack within 64 cycles", port);
        end
        @(posedge clk); #1;
        if (port == 0) p0_stb = 1'b0;
        else p1_stb = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    function automatic logic [31:0] rnd_addr();
        int unsigned k;
        k = $urandom_range(0, 9);
        if (k == 0) return RAM_BASE + 32'(RAM_DEPTH) + 32'($urandom_range(0, 7) * 4);
        else if (k == 1) return RAM_BASE - 32'($urandom_range(1, 8) * 4);
        else if (k == 2) return RAM_BASE + 32'(RAM_DEPTH - 4);
        else return RAM_BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: actual=still running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        // Plain read, partial write and read-back, range boundaries.
        req(0, 1'b0, RAM_BASE + 32'h1000, 32'h0, 4'h0, 2);
        req(1, 1'b1, RAM_BASE + 32'h1004, 32'hAABB_CCDD, 4'b0011, 0);
        req(1, 1'b0, RAM_BASE + 32'h1004, 32'h0, 4'h0, 2);
        req(0, 1'b0, RAM_BASE + 32'h2000, 32'h0, 4'h0, 0);
        req(0, 1'b1, RAM_BASE + 32'h2000, 32'hFFFF_FFFF, 4'hF, 0);
        req(0, 1'b0, RAM_BASE - 32'h4, 32'h0, 4'h0, 0);
        req(0, 1'b0, RAM_BASE + 32'h1FFC, 32'h0, 4'h0, 3);
        // Both masters saturating the port: loader forced through periodically.
        fork
            for (int i = 0; i < 20; i++) req(0, 1'b0, RAM_BASE + 32'(i * 4), 32'h0, 4'h0, 0);
            for (int j = 0; j < 4; j++) req(1, 1'b0, RAM_BASE + 32'(64 + j * 4), 32'h0, 4'h0, 0);
        join
        repeat (3) begin @(posedge clk); #1; end
        // Interleaved masters, one request per cycle overall.
        fork
            for (int i = 0; i < 8; i++) req(0, 1'b0, RAM_BASE + 32'(i * 8), 32'h0, 4'h0, 1);
            begin
                @(posedge clk); #1;
                for (int j = 0; j < 8; j++) req(1, 1'b0, RAM_BASE + 32'(j * 8 + 4), 32'h0, 4'h0, 1);
            end
        join
        repeat (3) begin @(posedge clk); #1; end
        // Reset while a read is in flight.
        req(0, 1'b0, RAM_BASE + 32'h100, 32'h0, 4'h0, 0);
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        // Random traffic from both masters.
        fork
            for (int i = 0; i < 150; i++)
                req(0, 1'($urandom_range(0, 1)), rnd_addr(), $urandom, 4'($urandom),
                    int'($urandom_range(0, 2)));
            for (int j = 0; j < 150; j++)
                req(1, 1'($urandom_range(0, 1)), rnd_addr(), $urandom, 4'($urandom),
                    int'($urandom_range(0, 2)));
        join
        repeat (MEM_LAT + 4) begin @(posedge clk); #1; end
        chk("drain", 32'(q0.size() + q1.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
